// File: rtl/muxn_pkg.sv
// muxn_pkg: shared definitions for the muxn_pipe selector slice.
//   MUXN_MAX_IN  - largest supported input count
//   sel_width()  - select width for n inputs (never below 1)
//   skid_state_t - occupancy of the optional skid entry (MUXN_PIPE_SKID_EN)
package muxn_pkg;

   localparam int MUXN_MAX_IN = 16;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_t;

endpackage

// File: rtl/muxn_sel.sv
// muxn_sel: combinational NUM_IN:1 word selector.
//   i_d    - flattened inputs, word i = i_d[i*WIDTH +: WIDTH]
//   i_s    - binary select
//   o_data - selected word, all-zeros when i_s >= NUM_IN
//   o_oor  - high when i_s >= NUM_IN
module muxn_sel #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SELW   = 2
) (
   input  logic [NUM_IN*WIDTH-1:0] i_d,
   input  logic [SELW-1:0]         i_s,
   output logic [WIDTH-1:0]        o_data,
   output logic                    o_oor
);

   always_comb begin
      o_data = '0;
      o_oor  = (int'(i_s) >= NUM_IN);
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (i_s == SELW'(i)) o_data = i_d[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/muxn_pipe.sv
// muxn_pipe: N:1 selector with a registered valid/ready output stage.
//   clk, reset_n        - clock, asynchronous active-low reset
//   in_valid/in_ready   - upstream handshake for d/s
//   d, s                - flattened data inputs and binary select
//   out_valid/out_ready - downstream handshake for y/sel_q
//   y, sel_q            - registered selected word and the select that produced it
//   sel_err, err_clr    - sticky out-of-range select flag and its synchronous clear
// Build option: define MUXN_PIPE_SKID_EN to add a one-entry skid buffer, which
// makes in_ready a pure register output.
module muxn_pipe
   import muxn_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SELW   = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] d,
   input  logic [SELW-1:0]         s,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        y,
   output logic [SELW-1:0]         sel_q,
   output logic                    sel_err,
   input  logic                    err_clr
);

   if (NUM_IN < 2 || NUM_IN > MUXN_MAX_IN) begin : g_bad_num_in
      $error("muxn_pipe: NUM_IN out of range");
   end

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  sel;
   } stage_t;

   logic [WIDTH-1:0] w_data;
   logic             w_oor;
   logic             w_in_ready;
   logic             w_accept;
   stage_t           w_new;
   stage_t           r_out;
   logic             r_out_valid;
   logic             r_sel_err;

   muxn_sel #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SELW   (SELW)
   ) u_sel (
      .i_d    (d),
      .i_s    (s),
      .o_data (w_data),
      .o_oor  (w_oor)
   );

   assign w_new    = '{data: w_data, sel: s};
   assign w_accept = in_valid && w_in_ready;

`ifdef MUXN_PIPE_SKID_EN
   skid_state_t r_skid_state;
   stage_t      r_skid;

   assign w_in_ready = (r_skid_state == SKID_EMPTY);

   // The skid only fills while the output is stalled, so whenever the output
   // frees up a held skid entry drains first; no accept can coincide with it
   // because in_ready is low while the skid is full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_skid       <= '0;
         r_skid_state <= SKID_EMPTY;
      end else if (!r_out_valid || out_ready) begin
         if (r_skid_state == SKID_FULL) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_state <= SKID_EMPTY;
         end else if (w_accept) begin
            r_out       <= w_new;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid       <= w_new;
         r_skid_state <= SKID_FULL;
      end
   end
`else
   assign w_in_ready = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out       <= w_new;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                r_sel_err <= 1'b0;
      else if (w_accept && w_oor)  r_sel_err <= 1'b1;
      else if (err_clr)            r_sel_err <= 1'b0;
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_out.data;
   assign sel_q     = r_out.sel;
   assign sel_err   = r_sel_err;

endmodule
